load_store_aligner: RTL and testbench
=====================================

LOAD_STORE_ALIGNER -- requirements
Module: load_store_aligner

Interface
REQ-001 SHALL have parameter DW, default 32, data path width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CPU access request.
REQ-006 SHALL have port req_ready, output, 1, request accepted when both req_valid and req_ready are high.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DW=64).
REQ-009 SHALL have port req_unsigned, input, 1, 1 = zero-extend load, 0 = sign-extend load.
REQ-010 SHALL have port req_addr, input, AW, byte address.
REQ-011 SHALL have port req_wdata, input, DW, store data, right-justified.
REQ-012 SHALL have port mem_valid, output, 1, memory request.
REQ-013 SHALL have port mem_we, output, 1, memory write.
REQ-014 SHALL have port mem_addr, output, AW, address with low log2(DW/8) bits zero.
REQ-015 SHALL have port mem_be, output, DW/8, byte enables.
REQ-016 SHALL have port mem_wdata, output, DW, lane-shifted store data.
REQ-017 SHALL have port mem_ready, input, 1, memory completion; read data valid in the same cycle.
REQ-018 SHALL have port mem_rdata, input, DW, full-width read data.
REQ-019 SHALL have port rsp_valid, output, 1, single-cycle completion pulse.
REQ-020 SHALL have port rsp_rdata, output, DW, extended load result; 0 for stores.
REQ-021 SHALL have port rsp_misalign, output, 1, address-alignment exception flag, qualified by rsp_valid.

Function
REQ-022 SHALL implement the FSM states IDLE, MEM and RSP.
REQ-023 SHALL drive req_ready high only in IDLE.
REQ-024 SHALL, on acceptance, register all request fields; MEM on the next cycle if aligned, else RSP directly.
REQ-025 SHALL treat an access as aligned when addr mod 2^req_size == 0; req_size=3 with DW=32 SHALL be treated as misaligned.
REQ-026 SHALL hold mem_valid, mem_we, mem_addr, mem_be and mem_wdata stable throughout MEM until mem_ready is sampled high, then move to RSP.
REQ-027 SHALL set mem_be to 2^req_size contiguous ones starting at lane = addr mod (DW/8).
REQ-028 SHALL place store data in mem_wdata as req_wdata shifted left by 8 x lane, with unused bits 0.
REQ-029 SHALL, for a load, capture mem_rdata shifted right by 8 x lane, truncated to 8 x 2^req_size bits, then sign- or zero-extended to DW bits per req_unsigned; a full-width access SHALL be passed through unchanged.
REQ-030 SHALL assert rsp_valid for exactly one cycle in RSP, then return to IDLE; the earliest possible next acceptance is the following cycle.
REQ-031 SHALL make a misaligned request generate no mem_valid and respond 1 cycle after acceptance with rsp_misalign=1 and rsp_rdata=0.
REQ-032 SHALL give an aligned access a latency, from the acceptance edge to rsp_valid, of 2 + the number of mem_ready wait cycles.
REQ-033 SHALL ignore req_valid outside IDLE; mem_ready outside MEM SHALL be ignored.

Reset
REQ-034 SHALL, while rst is high, force the state to IDLE and drive req_ready=0, mem_valid=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0 and rsp_misalign=0; req_ready SHALL go to 1 in the first cycle after release.
REQ-035 SHALL abandon any in-flight access when reset is asserted mid-operation, with no response generated.

Structure
REQ-036 SHALL define the size encodings and FSM state encodings in the shared CPU package.
REQ-037 SHALL contain one combinational sub-module, load_extend, parameterised by DW, performing the lane shift, truncation and extension.

Verification
REQ-038 SHALL verify: LB at addr 0x3, mem_rdata 0x80FF_FF12, no wait states -> mem_be 1000, rsp_rdata 0xFFFF_FF80, rsp_valid 2 cycles after acceptance.
REQ-039 SHALL verify: LHU at addr 0x2, mem_rdata 0x8001_1234 -> mem_be 1100, rsp_rdata 0x0000_8001.
REQ-040 SHALL verify: SH at addr 0x6, wdata 0x0000_BEEF, 3 mem_ready wait cycles -> mem_addr 0x4, mem_be 1100, mem_wdata 0xBEEF_0000 held stable for 4 cycles, rsp_valid 5 cycles after acceptance.
REQ-041 SHALL verify: LW at addr 0x2 -> no mem_valid, rsp_misalign=1 one cycle after acceptance, rsp_rdata 0.
REQ-042 SHALL verify: DW=64, LD at addr 0x8, then LWU at addr 0xC with mem_rdata 0xF000_0001_xxxx_xxxx -> first load passes the full word, second returns 0x0000_0000_F000_0001.
REQ-043 SHALL verify: rst asserted during MEM -> mem_valid drops asynchronously, no rsp_valid, req_ready=1 on the cycle after release.

Source files
------------

// File: rtl/load_store_aligner_pkg.sv
// Shared CPU package for the load/store aligner: access-size and FSM state
// encodings plus small size-decoding helpers shared by the top and load_extend.
package load_store_aligner_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Low-order data-bit mask covering one access of the given size (64-bit max).
    function automatic logic [63:0] size_mask(input size_e s);
        case (s)
            SZ_BYTE: size_mask = 64'h0000_0000_0000_00FF;
            SZ_HALF: size_mask = 64'h0000_0000_0000_FFFF;
            SZ_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Lane-0 byte-enable pattern for the given size (8 lanes max).
    function automatic logic [7:0] size_be(input size_e s);
        case (s)
            SZ_BYTE: size_be = 8'h01;
            SZ_HALF: size_be = 8'h03;
            SZ_WORD: size_be = 8'h0F;
            default: size_be = 8'hFF;
        endcase
    endfunction

    // Natural alignment check; a dword access is never legal on a 32-bit path.
    function automatic logic is_aligned(input size_e s, input logic [2:0] addr_lo,
                                        input logic dw64);
        case (s)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = (addr_lo[0] == 1'b0);
            SZ_WORD: is_aligned = (addr_lo[1:0] == 2'b00);
            default: is_aligned = dw64 && (addr_lo == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/load_store_aligner_extend.sv
// load_extend: right-shifts read data by the byte lane, truncates to the
// access size and sign/zero-extends to DW bits. Purely combinational.
// Ports: rdata_i (full-width read data), lane_i (byte lane), size_i,
//        unsigned_i (1 = zero-extend), result_o (extended load value).
module load_extend
    import load_store_aligner_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0]              rdata_i,
    input  logic [$clog2(DW/8)-1:0]    lane_i,
    input  size_e                      size_i,
    input  logic                       unsigned_i,
    output logic [DW-1:0]              result_o
);

    logic [DW-1:0] shifted;
    logic [DW-1:0] lo_mask;
    logic          sign;

    // Extension via masks so a full-width access passes through untouched.
    always_comb begin
        shifted = rdata_i >> {lane_i, 3'b000};
        lo_mask = DW'(size_mask(size_i));
        case (size_i)
            SZ_BYTE: sign = shifted[7];
            SZ_HALF: sign = shifted[15];
            SZ_WORD: sign = shifted[31];
            default: sign = shifted[DW-1];
        endcase
        result_o = shifted & lo_mask;
        if (!unsigned_i && sign) begin
            result_o = result_o | ~lo_mask;
        end
    end

endmodule

// File: rtl/load_store_aligner.sv
// load_store_aligner: turns a CPU byte-addressed load/store into one aligned
// full-width memory access (byte enables + lane-shifted data) and returns the
// extended load result. Misaligned requests are answered without touching memory.
// Ports: clk/rst (async active-high); req_* CPU request (valid/ready handshake);
//        mem_* memory request held until mem_ready; rsp_* one-cycle response.
module load_store_aligner
    import load_store_aligner_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_misalign
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned LW = $clog2(BW);

    state_e          state_q, state_d;
    logic            we_q, we_d;
    size_e           size_q, size_d;
    logic            uns_q, uns_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            req_ready_q, req_ready_d;
    logic            mem_valid_q, mem_valid_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_misalign_q, rsp_misalign_d;

    size_e           req_size_e;
    logic [LW-1:0]   req_lane;
    logic            req_aligned;
    logic [BW-1:0]   req_be;
    logic [DW-1:0]   req_wdata_sh;
    logic [DW-1:0]   ext_rdata;

    // Decode the incoming request into lane, enables and shifted store data.
    always_comb begin
        req_size_e   = size_e'(req_size);
        req_lane     = req_addr[LW-1:0];
        req_aligned  = is_aligned(req_size_e, req_addr[2:0], DW == 64);
        req_be       = BW'(size_be(req_size_e)) << req_lane;
        req_wdata_sh = (req_wdata & DW'(size_mask(req_size_e))) << {req_lane, 3'b000};
    end

    load_extend #(.DW(DW)) u_load_extend (
        .rdata_i    (mem_rdata),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ext_rdata)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        uns_d          = uns_q;
        lane_d         = lane_q;
        mem_valid_d    = mem_valid_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_be_d       = mem_be_q;
        mem_wdata_d    = mem_wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_misalign_d = rsp_misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d   = req_we;
                    size_d = req_size_e;
                    uns_d  = req_unsigned;
                    lane_d = req_lane;
                    if (req_aligned) begin
                        state_d     = ST_MEM;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr & ~AW'(BW - 1);
                        mem_be_d    = req_be;
                        mem_wdata_d = req_we ? req_wdata_sh : '0;
                    end else begin
                        state_d        = ST_RSP;
                        rsp_valid_d    = 1'b1;
                        rsp_misalign_d = 1'b1;
                        rsp_rdata_d    = '0;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d        = ST_RSP;
                    mem_valid_d    = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_addr_d     = '0;
                    mem_be_d       = '0;
                    mem_wdata_d    = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_misalign_d = 1'b0;
                    rsp_rdata_d    = we_q ? '0 : ext_rdata;
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            we_q           <= 1'b0;
            size_q         <= SZ_BYTE;
            uns_q          <= 1'b0;
            lane_q         <= '0;
            req_ready_q    <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_be_q       <= '0;
            mem_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            lane_q         <= lane_d;
            req_ready_q    <= req_ready_d;
            mem_valid_q    <= mem_valid_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_be_q       <= mem_be_d;
            mem_wdata_q    <= mem_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign mem_valid    = mem_valid_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_misalign = rsp_misalign_q;

endmodule

// File: tb/tb_load_store_aligner.sv
// Scoreboard bench: a 32-bit and a 64-bit aligner driven by directed vectors.
// Issue tasks push expected memory requests and responses; a memory responder
// and a response monitor per instance pop and compare independently.
module tb_load_store_aligner;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          waits;
        logic [63:0] mrdata;
        logic        exp_mis;
        logic [63:0] exp_rdata;
        logic [31:0] exp_maddr;
        logic [7:0]  exp_be;
        logic [63:0] exp_mwdata;
        int          exp_lat;
        int          issue_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // 32-bit instance signals
    logic        req_valid_a = 0, req_we_a = 0, req_unsigned_a = 0, req_ready_a;
    logic [1:0]  req_size_a = 0;
    logic [31:0] req_addr_a = 0, req_wdata_a = 0;
    logic        mem_valid_a, mem_we_a, mem_ready_a = 0;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a = 0;
    logic [3:0]  mem_be_a;
    logic        rsp_valid_a, rsp_misalign_a;
    logic [31:0] rsp_rdata_a;

    // 64-bit instance signals
    logic        req_valid_b = 0, req_we_b = 0, req_unsigned_b = 0, req_ready_b;
    logic [1:0]  req_size_b = 0;
    logic [31:0] req_addr_b = 0;
    logic [63:0] req_wdata_b = 0;
    logic        mem_valid_b, mem_we_b, mem_ready_b = 0;
    logic [31:0] mem_addr_b;
    logic [63:0] mem_wdata_b, mem_rdata_b = 0;
    logic [7:0]  mem_be_b;
    logic        rsp_valid_b, rsp_misalign_b;
    logic [63:0] rsp_rdata_b;

    load_store_aligner #(.DW(32), .AW(32)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_size(req_size_a), .req_unsigned(req_unsigned_a), .req_addr(req_addr_a),
        .req_wdata(req_wdata_a),
        .mem_valid(mem_valid_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_be(mem_be_a), .mem_wdata(mem_wdata_a), .mem_ready(mem_ready_a),
        .mem_rdata(mem_rdata_a),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_misalign(rsp_misalign_a)
    );

    load_store_aligner #(.DW(64), .AW(32)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_size(req_size_b), .req_unsigned(req_unsigned_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b),
        .mem_valid(mem_valid_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_be(mem_be_b), .mem_wdata(mem_wdata_b), .mem_ready(mem_ready_b),
        .mem_rdata(mem_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_misalign(rsp_misalign_b)
    );

    txn_t mem_q_a[$], rsp_q_a[$], mem_q_b[$], rsp_q_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input int waits, input logic [63:0] mrdata,
                                input logic mis, input logic [63:0] erd,
                                input logic [31:0] maddr, input logic [7:0] be,
                                input logic [63:0] mwd, input int lat);
        txn_t t;
        t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
        t.waits = waits; t.mrdata = mrdata; t.exp_mis = mis; t.exp_rdata = erd;
        t.exp_maddr = maddr; t.exp_be = be; t.exp_mwdata = mwd; t.exp_lat = lat;
        t.issue_cyc = 0;
        return t;
    endfunction

    task automatic issue_a(input txn_t t);
        int n = 0;
        @(negedge clk);
        while (!req_ready_a && n < 50) begin @(negedge clk); n++; end
        if (!req_ready_a) begin
            total++;
            $display("FAIL a_req_ready_timeout: got 0 expected 1");
            return;
        end
        req_we_a = t.we; req_size_a = t.size; req_unsigned_a = t.uns;
        req_addr_a = t.addr; req_wdata_a = t.wdata[31:0]; req_valid_a = 1'b1;
        t.issue_cyc = cyc;
        rsp_q_a.push_back(t);
        if (!t.exp_mis) mem_q_a.push_back(t);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_addr_a = 32'hFFFF_FFFF;
    endtask

    task automatic issue_b(input txn_t t);
        int n = 0;
        @(negedge clk);
        while (!req_ready_b && n < 50) begin @(negedge clk); n++; end
        if (!req_ready_b) begin
            total++;
            $display("FAIL b_req_ready_timeout: got 0 expected 1");
            return;
        end
        req_we_b = t.we; req_size_b = t.size; req_unsigned_b = t.uns;
        req_addr_b = t.addr; req_wdata_b = t.wdata; req_valid_b = 1'b1;
        t.issue_cyc = cyc;
        rsp_q_b.push_back(t);
        if (!t.exp_mis) mem_q_b.push_back(t);
        @(negedge clk);
        req_valid_b = 1'b0;
        req_addr_b = 32'hFFFF_FFFF;
    endtask

    // Memory responder A: checks request fields every cycle mem_valid is high.
    txn_t cur_a; bit in_a = 0; int wcnt_a = 0;
    always @(negedge clk) begin
        if (rst) begin
            in_a = 0; mem_ready_a = 1'b0;
        end else if (mem_valid_a) begin
            if (!in_a) begin
                total++;
                if (mem_q_a.size() == 0) begin
                    $display("FAIL a_unexpected_mem_valid: got 1 expected 0 (t=%0t)", $time);
                    mem_ready_a = 1'b0;
                end else begin
                    passed++;
                    cur_a = mem_q_a.pop_front(); in_a = 1; wcnt_a = 0;
                end
            end
            if (in_a) begin
                chk("a_mem_we",    64'(mem_we_a),    64'(cur_a.we));
                chk("a_mem_addr",  64'(mem_addr_a),  64'(cur_a.exp_maddr));
                chk("a_mem_be",    64'(mem_be_a),    64'(cur_a.exp_be));
                chk("a_mem_wdata", 64'(mem_wdata_a), cur_a.exp_mwdata);
                if (wcnt_a == cur_a.waits) begin
                    mem_ready_a = 1'b1; mem_rdata_a = cur_a.mrdata[31:0]; in_a = 0;
                end else begin
                    mem_ready_a = 1'b0; mem_rdata_a = $urandom; wcnt_a++;
                end
            end
        end else begin
            // Idle-time mem_ready must be ignored by the DUT.
            mem_ready_a = 1'b1; mem_rdata_a = 32'hDEAD_0BAD;
        end
    end

    txn_t cur_b; bit in_b = 0; int wcnt_b = 0;
    always @(negedge clk) begin
        if (rst) begin
            in_b = 0; mem_ready_b = 1'b0;
        end else if (mem_valid_b) begin
            if (!in_b) begin
                total++;
                if (mem_q_b.size() == 0) begin
                    $display("FAIL b_unexpected_mem_valid: got 1 expected 0 (t=%0t)", $time);
                    mem_ready_b = 1'b0;
                end else begin
                    passed++;
                    cur_b = mem_q_b.pop_front(); in_b = 1; wcnt_b = 0;
                end
            end
            if (in_b) begin
                chk("b_mem_we",    64'(mem_we_b),   64'(cur_b.we));
                chk("b_mem_addr",  64'(mem_addr_b), 64'(cur_b.exp_maddr));
                chk("b_mem_be",    64'(mem_be_b),   64'(cur_b.exp_be));
                chk("b_mem_wdata", mem_wdata_b,     cur_b.exp_mwdata);
                if (wcnt_b == cur_b.waits) begin
                    mem_ready_b = 1'b1; mem_rdata_b = cur_b.mrdata; in_b = 0;
                end else begin
                    mem_ready_b = 1'b0; mem_rdata_b = {$urandom, $urandom}; wcnt_b++;
                end
            end
        end else begin
            mem_ready_b = 1'b1; mem_rdata_b = 64'hDEAD_0BAD_DEAD_0BAD;
        end
    end

    // Response monitors: latency measured in edges from acceptance to sampling.
    txn_t er_a, er_b;
    always @(negedge clk) begin
        if (!rst && rsp_valid_a) begin
            if (rsp_q_a.size() == 0) begin
                total++;
                $display("FAIL a_unexpected_rsp: got 1 expected 0 (t=%0t)", $time);
            end else begin
                er_a = rsp_q_a.pop_front();
                chk("a_rsp_rdata",    64'(rsp_rdata_a),    er_a.exp_rdata);
                chk("a_rsp_misalign", 64'(rsp_misalign_a), 64'(er_a.exp_mis));
                chk("a_rsp_latency",  64'(cyc - er_a.issue_cyc), 64'(er_a.exp_lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid_b) begin
            if (rsp_q_b.size() == 0) begin
                total++;
                $display("FAIL b_unexpected_rsp: got 1 expected 0 (t=%0t)", $time);
            end else begin
                er_b = rsp_q_b.pop_front();
                chk("b_rsp_rdata",    rsp_rdata_b,         er_b.exp_rdata);
                chk("b_rsp_misalign", 64'(rsp_misalign_b), 64'(er_b.exp_mis));
                chk("b_rsp_latency",  64'(cyc - er_b.issue_cyc), 64'(er_b.exp_lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("a_rst_req_ready",    64'(req_ready_a),    64'd0);
        chk("a_rst_mem_valid",    64'(mem_valid_a),    64'd0);
        chk("a_rst_mem_we",       64'(mem_we_a),       64'd0);
        chk("a_rst_mem_addr",     64'(mem_addr_a),     64'd0);
        chk("a_rst_mem_be",       64'(mem_be_a),       64'd0);
        chk("a_rst_mem_wdata",    64'(mem_wdata_a),    64'd0);
        chk("a_rst_rsp_valid",    64'(rsp_valid_a),    64'd0);
        chk("a_rst_rsp_rdata",    64'(rsp_rdata_a),    64'd0);
        chk("a_rst_rsp_misalign", 64'(rsp_misalign_a), 64'd0);
        chk("b_rst_req_ready",    64'(req_ready_b),    64'd0);
        chk("b_rst_mem_valid",    64'(mem_valid_b),    64'd0);
        chk("b_rst_rsp_rdata",    rsp_rdata_b,         64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("a_req_ready_after_rst", 64'(req_ready_a), 64'd1);
        chk("b_req_ready_after_rst", 64'(req_ready_b), 64'd1);

        // 32-bit vectors: we size uns addr wdata waits mrdata | mis rdata maddr be mwdata lat
        issue_a(mk(0, 2'd0, 0, 32'h3,   64'h1111_2222, 0, 64'h80FF_FF12, 0, 64'hFFFF_FF80, 32'h0,   8'h8, 64'h0,         2));
        issue_a(mk(0, 2'd1, 1, 32'h2,   64'h0,         1, 64'h8001_1234, 0, 64'h0000_8001, 32'h0,   8'hC, 64'h0,         3));
        issue_a(mk(1, 2'd1, 0, 32'h6,   64'h0000_BEEF, 3, 64'h0,         0, 64'h0,         32'h4,   8'hC, 64'hBEEF_0000, 5));
        issue_a(mk(0, 2'd2, 0, 32'h2,   64'h0,         0, 64'h0,         1, 64'h0,         32'h0,   8'h0, 64'h0,         1));
        issue_a(mk(0, 2'd1, 0, 32'h11,  64'h0,         0, 64'h0,         1, 64'h0,         32'h0,   8'h0, 64'h0,         1));
        issue_a(mk(0, 2'd0, 0, 32'h1,   64'h0,         0, 64'h1234_7F00, 0, 64'h0000_007F, 32'h0,   8'h2, 64'h0,         2));
        issue_a(mk(0, 2'd1, 0, 32'h22,  64'h0,         0, 64'hC3A5_0000, 0, 64'hFFFF_C3A5, 32'h20,  8'hC, 64'h0,         2));
        issue_a(mk(1, 2'd0, 0, 32'h101, 64'hDEAD_BEAB, 2, 64'h0,         0, 64'h0,         32'h100, 8'h2, 64'h0000_AB00, 4));
        issue_a(mk(1, 2'd2, 0, 32'h40,  64'h1234_5678, 0, 64'h0,         0, 64'h0,         32'h40,  8'hF, 64'h1234_5678, 2));
        issue_a(mk(0, 2'd2, 1, 32'h44,  64'h0,         0, 64'h8765_4321, 0, 64'h8765_4321, 32'h44,  8'hF, 64'h0,         2));
        issue_a(mk(0, 2'd3, 0, 32'h8,   64'h0,         0, 64'h0,         1, 64'h0,         32'h0,   8'h0, 64'h0,         1));

        // Reset in the middle of a memory access: abandoned, no response.
        issue_a(mk(0, 2'd2, 0, 32'h50, 64'h0, 6, 64'h0, 0, 64'h0, 32'h50, 8'hF, 64'h0, 8));
        #2 rst = 1'b1;
        #1 chk("a_rst_mid_mem_valid_async", 64'(mem_valid_a), 64'd0);
        chk("a_rst_mid_rsp_valid", 64'(rsp_valid_a), 64'd0);
        if (rsp_q_a.size() != 0) void'(rsp_q_a.pop_back());
        @(negedge clk);
        chk("a_rst_mid_req_ready", 64'(req_ready_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("a_req_ready_after_mid_rst", 64'(req_ready_a), 64'd1);
        issue_a(mk(0, 2'd0, 1, 32'h2, 64'h0, 0, 64'h00F0_0000, 0, 64'h0000_00F0, 32'h0, 8'h4, 64'h0, 2));

        // 64-bit vectors
        issue_b(mk(0, 2'd3, 0, 32'h8,  64'h0, 0, 64'hF000_0001_DEAD_BEEF, 0, 64'hF000_0001_DEAD_BEEF, 32'h8,  8'hFF, 64'h0, 2));
        issue_b(mk(0, 2'd2, 1, 32'hC,  64'h0, 0, 64'hF000_0001_DEAD_BEEF, 0, 64'h0000_0000_F000_0001, 32'h8,  8'hF0, 64'h0, 2));
        issue_b(mk(0, 2'd2, 0, 32'hC,  64'h0, 1, 64'hF000_0001_DEAD_BEEF, 0, 64'hFFFF_FFFF_F000_0001, 32'h8,  8'hF0, 64'h0, 3));
        issue_b(mk(1, 2'd3, 0, 32'h10, 64'h0123_4567_89AB_CDEF, 2, 64'h0, 0, 64'h0, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 4));
        issue_b(mk(1, 2'd0, 0, 32'h17, 64'hFFFF_FF55, 0, 64'h0, 0, 64'h0, 32'h10, 8'h80, 64'h5500_0000_0000_0000, 2));
        issue_b(mk(0, 2'd3, 0, 32'h4,  64'h0, 0, 64'h0, 1, 64'h0, 32'h0, 8'h00, 64'h0, 1));

        // Drain outstanding expectations within a bounded window.
        n = 0;
        while ((rsp_q_a.size() + rsp_q_b.size() + mem_q_a.size() + mem_q_b.size()) != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (4) @(negedge clk);
        chk("a_pending_rsp", 64'(rsp_q_a.size()), 64'd0);
        chk("b_pending_rsp", 64'(rsp_q_b.size()), 64'd0);
        chk("a_pending_mem", 64'(mem_q_a.size()), 64'd0);
        chk("b_pending_mem", 64'(mem_q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
